// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared mode encodings and output-stage state type for stream_mux_rr
package stream_mux_pkg;

   localparam logic MODE_SEL = 1'b0;
   localparam logic MODE_RR  = 1'b1;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational pointer-based priority picker
module rr_arbiter #(
   parameter int NUM_CH = 4,
   localparam int SEL_W = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   output logic [NUM_CH-1:0] gnt,
   output logic [SEL_W-1:0]  gnt_idx,
   output logic              any_gnt
);

   int               cand;
   logic [SEL_W-1:0] cidx;

   // Walk upward from ptr with wrap; the first requester found wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any_gnt = 1'b0;
      cand    = 0;
      cidx    = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         cand = int'(ptr) + k;
         if (cand >= NUM_CH) cand = cand - NUM_CH;
         cidx = SEL_W'(cand);
         if (!any_gnt && req[cidx]) begin
            gnt[cidx] = 1'b1;
            gnt_idx   = cidx;
            any_gnt   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel valid/ready stream mux, direct or round-robin, registered output
module stream_mux_rr
   import stream_mux_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 8,
   localparam int SEL_W = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     mode,
   input  logic [SEL_W-1:0]         sel,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   input  logic [NUM_CH-1:0]        in_valid,
   output logic [NUM_CH-1:0]        in_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic [SEL_W-1:0]         out_ch,
   output logic                     out_valid,
   input  logic                     out_ready
);

   out_state_t        state;
   logic [SEL_W-1:0]  ptr;
   logic [NUM_CH-1:0] rr_gnt;
   logic [SEL_W-1:0]  rr_idx;
   logic              rr_any;
   logic [NUM_CH-1:0] grant;
   logic [SEL_W-1:0]  gnt_idx;
   logic              any_gnt;
   logic              load_en;
   logic              xfer;
   logic [DATA_W-1:0] ch_data [NUM_CH];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
      assign ch_data[i] = in_data[i*DATA_W +: DATA_W];
   end

   rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .req     (in_valid),
      .ptr     (ptr),
      .gnt     (rr_gnt),
      .gnt_idx (rr_idx),
      .any_gnt (rr_any)
   );

   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      any_gnt = 1'b0;
      if (mode == MODE_RR) begin
         grant   = rr_gnt;
         gnt_idx = rr_idx;
         any_gnt = rr_any;
      end else if (int'(sel) < NUM_CH && in_valid[sel]) begin
         grant[sel] = 1'b1;
         gnt_idx    = sel;
         any_gnt    = 1'b1;
      end
   end

   assign load_en   = (state == ST_EMPTY) | out_ready;
   // Gate with rst_n so no producer sees a handshake while the stage is held in reset.
   assign in_ready  = (rst_n && load_en) ? grant : '0;
   assign xfer      = any_gnt & load_en;
   assign out_valid = (state == ST_FULL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_EMPTY;
         out_data <= '0;
         out_ch   <= '0;
         ptr      <= '0;
      end else if (xfer) begin
         state    <= ST_FULL;
         out_data <= ch_data[gnt_idx];
         out_ch   <= gnt_idx;
         ptr      <= (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
      end else if (out_ready) begin
         state <= ST_EMPTY;
      end
   end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - directed self-checking bench for stream_mux_rr
module tb_stream_mux_rr;

   localparam int NUM_CH = 4;
   localparam int DATA_W = 8;
   localparam int SEL_W  = 2;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     mode;
   logic [SEL_W-1:0]         sel;
   logic [NUM_CH*DATA_W-1:0] in_data;
   logic [NUM_CH-1:0]        in_valid;
   logic [NUM_CH-1:0]        in_ready;
   logic [DATA_W-1:0]        out_data;
   logic [SEL_W-1:0]         out_ch;
   logic                     out_valid;
   logic                     out_ready;

   logic [DATA_W-1:0] ch_val [NUM_CH];
   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   stream_mux_rr #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .sel       (sel),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_beat(input string tag, input int ch);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_ch"}, 32'(out_ch), 32'(ch));
      check({tag, "_data"}, 32'(out_data), 32'(ch_val[ch]));
   endtask

   initial begin
      ch_val[0] = 8'h10;
      ch_val[1] = 8'h21;
      ch_val[2] = 8'hA5;
      ch_val[3] = 8'h3C;
      in_data   = {ch_val[3], ch_val[2], ch_val[1], ch_val[0]};
      rst_n     = 1'b0;
      mode      = 1'b1;
      sel       = 2'd1;
      in_valid  = 4'b1111;
      out_ready = 1'b1;

      step();
      step();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_ch", 32'(out_ch), 32'd0);
      check("rst_ready", 32'(in_ready), 32'b0000);

      // direct select, ch2
      rst_n = 1'b1;
      mode  = 1'b0;
      sel   = 2'd2;
      #1 check("dir_ready", 32'(in_ready), 32'b0100);
      step();
      check_beat("dir_ch2", 2);

      // direct ch3 leaves ptr at 0, so RR resumes from ch0
      sel = 2'd3;
      #1 check("dir3_ready", 32'(in_ready), 32'b1000);
      step();
      check_beat("dir_ch3", 3);

      mode = 1'b1;
      #1 check("sw_ready", 32'(in_ready), 32'b0001);
      for (int i = 0; i < 8; i++) begin
         step();
         check_beat($sformatf("rr_all%0d", i), i % 4);
      end

      in_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         step();
         check_beat($sformatf("rr_odd%0d", i), (i % 2 == 0) ? 1 : 3);
      end

      // back-pressure holds the ch3 beat
      out_ready = 1'b0;
      in_valid  = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         #1 check($sformatf("bp_ready%0d", i), 32'(in_ready), 32'b0000);
         step();
         check_beat($sformatf("bp_hold%0d", i), 3);
      end

      out_ready = 1'b1;
      in_valid  = 4'b0010;
      #1 check("bp_release_ready", 32'(in_ready), 32'b0010);
      step();
      check_beat("bp_reload", 1);

      in_valid = 4'b0000;
      step();
      check("drain_valid", 32'(out_valid), 32'd0);
      check("drain_ch_hold", 32'(out_ch), 32'd1);
      check("drain_data_hold", 32'(out_data), 32'(ch_val[1]));

      // ptr=2 now; load ch2 and hold it FULL, then reset between edges
      in_valid = 4'b1111;
      step();
      check_beat("pre_rst", 2);
      out_ready = 1'b0;
      #1 rst_n = 1'b0;
      #1 check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_ready", 32'(in_ready), 32'b0000);
      check("arst_ch", 32'(out_ch), 32'd0);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      #1 check("post_rst_ready", 32'(in_ready), 32'b0001);
      step();
      check_beat("post_rst0", 0);
      step();
      check_beat("post_rst1", 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, W-bit streaming multiplexer with a valid/ready handshake on every input and on the output. It is the registered, back-pressured successor to the team's fixed 4:1 bit multiplexer. Channel choice is either direct, driven by an external select, or round-robin across valid requesters. It sits between several producer streams and a single consumer, with one registered output stage.

## Interface
- NUM_CH, 4, number of input channels (≥2)
- DATA_W, 8, payload width per channel
- SEL_W, $clog2(NUM_CH), channel index width (derived, not overridden)
- clk  input  1  rising-edge clock; one clock domain
- rst_n  input  1  reset, asynchronous and active-low
- mode  input  1  0 = direct select, 1 = round-robin
- sel  input  SEL_W  channel index used in direct mode
- in_data  input  NUM_CH*DATA_W  channel i payload at bits [i*DATA_W +: DATA_W]
- in_valid  input  NUM_CH  per-channel valid
- in_ready  output  NUM_CH  per-channel ready, combinational
- out_data  output  DATA_W  registered payload
- out_ch  output  SEL_W  registered index of the source channel
- out_valid  output  1  registered valid
- out_ready  input  1  consumer ready

## Operation
- Output stage is a single-entry register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
- Output stage can load when `load_en = !out_valid | out_ready`.
- Grant selection, one-hot, at most one bit set:
  - Direct mode: grant channel `sel` only if in_valid[sel]=1. If sel ≥ NUM_CH, there is no grant.
  - RR mode: grant the first valid channel found by searching upward from `ptr`, wrapping from NUM_CH-1 to 0.
- in_ready[i] = grant[i] & load_en. A transfer on channel i occurs when in_valid[i] & in_ready[i].
- On a transfer from channel g: out_data <= channel g payload, out_ch <= g, out_valid <= 1, and ptr <= (g+1) mod NUM_CH.
- ptr updates in both modes, so switching to RR resumes after the last-served channel.
- No transfer and out_ready=1: out_valid <= 0. out_data and out_ch hold their values.
- FULL and out_ready=0: out_data, out_ch and out_valid hold; every in_ready is 0.
- Simultaneous drain and load in the same cycle is allowed. The new beat replaces the old one with no bubble.
- mode and sel are sampled combinationally every cycle. A change affects only the next grant and never an already registered beat.
- Inputs must not depend combinationally on in_ready. out_valid must not depend on out_ready.

## Timing
- Reset, asynchronous assert: out_valid=0, out_data=0, out_ch=0, ptr=0, state EMPTY. in_ready is all-zero while rst_n=0.
- Reset mid-stream discards the registered beat. After release the first grant follows ptr=0.
- Latency from input transfer to out_valid is 1 cycle.
- Throughput is 1 beat per cycle while out_ready stays high.
- RR fairness: with all channels valid and out_ready=1, channels are served 0,1,…,NUM_CH-1,0,… with one beat each per cycle.
- Pointer wrap: a grant to NUM_CH-1 sets ptr=0.

## Structure
- Shared package `stream_mux_pkg` holds MODE_SEL=1'b0 and MODE_RR=1'b1.
- One sub-module, `rr_arbiter`: a purely combinational, pointer-based priority picker.
  - Inputs: req[NUM_CH], ptr[SEL_W].
  - Outputs: one-hot gnt, gnt_idx, any_gnt.
- The top level holds the direct/RR grant mux, the output register and the ptr register.

## Test plan
- Reset: hold rst_n=0 with all inputs active -> out_valid=0, out_data=0, out_ch=0, in_ready=0000. Release rst_n -> first beat appears 1 cycle after the first transfer.
- Direct mode: mode=0, sel=2, in_valid=1111, ch2 data=8'hA5 -> in_ready=0100. Next cycle out_data=8'hA5, out_ch=2.
- RR mode: mode=1, all valid, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 with no bubbles. Then in_valid=1010 -> sequence 1,3,1,3.
- Back-pressure: out_valid=1, out_ready=0 for 3 cycles -> out_data/out_ch stable and in_ready=0000. Raise out_ready with ch1 valid -> drain and ch1 load happen in the same cycle.
- Mode switch: in direct mode serve ch3, then set mode=1 with all valid -> next grant is ch0 (wrap from ptr=0 after ch3).
- Async reset mid-stream: pulse rst_n low between clock edges while FULL -> out_valid drops immediately. After release, the RR grant restarts at ch0.
